// File: rtl/sync_fifo_wm.sv
// sync_fifo_wm: synchronous FIFO with programmable almost-full/almost-empty
// watermarks, selectable overflow policy, selectable read mode, a saturating
// drop counter and a clearable high-water mark.
//
// Parameters:
//   W         data width
//   DEPTH     number of entries (>= 2, need not be a power of two)
//   FWFT      1 = head word shown combinationally, 0 = registered read
//   OVF_MODE  0 = drop incoming word when full, 1 = overwrite oldest word
//   DROPW     drop counter width
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   push, push_data            write request and data
//   pop, pop_data, pop_valid   read request, read data and its qualifier
//   empty, full, count         occupancy status
//   afull_thresh, aempty_thresh, almost_full, almost_empty   watermarks
//   overflow, underflow        one-cycle event pulses
//   drop_count                 words lost to overflow (saturating)
//   hwm, hwm_clr               high-water mark and its reload strobe
module sync_fifo_wm #(
    parameter int W        = 72,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 1,
    parameter int OVF_MODE = 0,
    parameter int DROPW    = 16,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic             pop_valid,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    input  logic [CW-1:0]    afull_thresh,
    input  logic [CW-1:0]    aempty_thresh,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    output logic [DROPW-1:0] drop_count,
    output logic [CW-1:0]    hwm,
    input  logic             hwm_clr
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_inc;
    logic [PW-1:0] rptr_inc;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          do_pop;
    logic          do_push;
    logic          drop_evt;
    logic          overwrite;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign count        = count_q;
    assign almost_full  = (count_q >= afull_thresh);
    assign almost_empty = (count_q <= aempty_thresh);

    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    // A push against a full FIFO with no pop to make room is a loss event in
    // both policies; only drop-oldest actually writes.
    assign drop_evt  = push & full & ~do_pop;
    assign overwrite = drop_evt & (OVF_MODE != 0);

    // Explicit wrap so non-power-of-two depths work.
    assign wptr_inc = (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
    assign rptr_inc = (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);

    // Overwrite keeps count at DEPTH: it is neither push-only nor pop-only.
    always_comb begin
        count_next = count_q;
        if (do_push && !do_pop) begin
            count_next = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (do_push || overwrite)) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            drop_count <= '0;
            hwm        <= '0;
        end else begin
            if (do_push || overwrite) begin
                wptr <= wptr_inc;
            end
            if (do_pop || overwrite) begin
                rptr <= rptr_inc;
            end
            count_q   <= count_next;
            overflow  <= drop_evt;
            underflow <= pop & empty;
            if (drop_evt && (drop_count != '1)) begin
                drop_count <= drop_count + DROPW'(1);
            end
            if (hwm_clr) begin
                hwm <= count_next;
            end else if (count_next > hwm) begin
                hwm <= count_next;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign pop_data  = empty ? '0 : mem[rptr];
            assign pop_valid = ~empty;
        end else begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    pop_data  <= '0;
                    pop_valid <= 1'b0;
                end else begin
                    pop_valid <= do_pop;
                    if (do_pop) begin
                        pop_data <= mem[rptr];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_wm.sv
// Bench for sync_fifo_wm. Two instances share push/pop stimulus:
//   u0: DEPTH=16, FWFT=1, OVF_MODE=0, DROPW=16
//   u1: DEPTH=5,  FWFT=0, OVF_MODE=1, DROPW=3 (drop counter saturates at 7)
// A queue-based reference model predicts every output after each edge.
module tb_sync_fifo_wm;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic       pop;
    logic       hwm_clr;
    logic [7:0] push_data;
    logic [4:0] af0, ae0;
    logic [2:0] af1, ae1;

    logic [7:0]  pd0, pd1;
    logic        pv0, pv1, e0, e1, f0, f1;
    logic        afu0, afu1, aem0, aem1;
    logic        ovf0, ovf1, udf0, udf1;
    logic [4:0]  c0, hwm0;
    logic [2:0]  c1, hwm1;
    logic [15:0] dc0;
    logic [2:0]  dc1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sync_fifo_wm #(.W(8), .DEPTH(16), .FWFT(1), .OVF_MODE(0), .DROPW(16)) u0 (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pd0), .pop_valid(pv0), .empty(e0), .full(f0), .count(c0),
        .afull_thresh(af0), .aempty_thresh(ae0), .almost_full(afu0),
        .almost_empty(aem0), .overflow(ovf0), .underflow(udf0),
        .drop_count(dc0), .hwm(hwm0), .hwm_clr(hwm_clr)
    );

    sync_fifo_wm #(.W(8), .DEPTH(5), .FWFT(0), .OVF_MODE(1), .DROPW(3)) u1 (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pd1), .pop_valid(pv1), .empty(e1), .full(f1), .count(c1),
        .afull_thresh(af1), .aempty_thresh(ae1), .almost_full(afu1),
        .almost_empty(aem1), .overflow(ovf1), .underflow(udf1),
        .drop_count(dc1), .hwm(hwm1), .hwm_clr(hwm_clr)
    );

    // Reference model state, index 0 -> u0, 1 -> u1.
    logic [7:0] mq [2][$];
    int         m_drop [2];
    int         m_hwm  [2];
    bit         m_ovf  [2];
    bit         m_udf  [2];
    bit         m_pv   [2];
    logic [7:0] m_pd   [2];
    int         m_depth   [2] = '{16, 5};
    bit         m_fwft    [2] = '{1'b1, 1'b0};
    bit         m_oldest  [2] = '{1'b0, 1'b1};
    int         m_dropmax [2] = '{65535, 7};

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int  sz;
            bit  popping;
            logic [7:0] w;
            if (rst) begin
                mq[i].delete();
                m_drop[i] = 0;
                m_hwm[i]  = 0;
                m_ovf[i]  = 1'b0;
                m_udf[i]  = 1'b0;
                m_pv[i]   = 1'b0;
                m_pd[i]   = 8'h00;
            end else begin
                sz       = mq[i].size();
                popping  = pop && (sz > 0);
                m_udf[i] = pop && (sz == 0);
                m_ovf[i] = push && (sz == m_depth[i]) && !popping;
                m_pv[i]  = 1'b0;
                if (popping) begin
                    w = mq[i].pop_front();
                    if (!m_fwft[i]) begin
                        m_pv[i] = 1'b1;
                        m_pd[i] = w;
                    end
                end
                if (push) begin
                    if (sz < m_depth[i] || popping) begin
                        mq[i].push_back(push_data);
                    end else if (m_oldest[i]) begin
                        w = mq[i].pop_front();
                        mq[i].push_back(push_data);
                    end
                end
                if (m_ovf[i] && m_drop[i] < m_dropmax[i]) m_drop[i]++;
                if (hwm_clr) m_hwm[i] = mq[i].size();
                else if (mq[i].size() > m_hwm[i]) m_hwm[i] = mq[i].size();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
            $error("%s differs from model", tag);
        end
    endtask

    task automatic check_all();
        int s0, s1;
        s0 = mq[0].size();
        s1 = mq[1].size();
        chk("u0.count",        32'(c0),   32'(s0));
        chk("u0.empty",        32'(e0),   32'(s0 == 0));
        chk("u0.full",         32'(f0),   32'(s0 == 16));
        chk("u0.almost_full",  32'(afu0), 32'(s0 >= int'(af0)));
        chk("u0.almost_empty", 32'(aem0), 32'(s0 <= int'(ae0)));
        chk("u0.overflow",     32'(ovf0), 32'(m_ovf[0]));
        chk("u0.underflow",    32'(udf0), 32'(m_udf[0]));
        chk("u0.drop_count",   32'(dc0),  32'(m_drop[0]));
        chk("u0.hwm",          32'(hwm0), 32'(m_hwm[0]));
        chk("u0.pop_valid",    32'(pv0),  32'(s0 > 0));
        chk("u0.pop_data",     32'(pd0),  (s0 > 0) ? 32'(mq[0][0]) : 32'd0);
        chk("u1.count",        32'(c1),   32'(s1));
        chk("u1.empty",        32'(e1),   32'(s1 == 0));
        chk("u1.full",         32'(f1),   32'(s1 == 5));
        chk("u1.almost_full",  32'(afu1), 32'(s1 >= int'(af1)));
        chk("u1.almost_empty", 32'(aem1), 32'(s1 <= int'(ae1)));
        chk("u1.overflow",     32'(ovf1), 32'(m_ovf[1]));
        chk("u1.underflow",    32'(udf1), 32'(m_udf[1]));
        chk("u1.drop_count",   32'(dc1),  32'(m_drop[1]));
        chk("u1.hwm",          32'(hwm1), 32'(m_hwm[1]));
        chk("u1.pop_valid",    32'(pv1),  32'(m_pv[1]));
        chk("u1.pop_data",     32'(pd1),  32'(m_pd[1]));
    endtask

    task automatic cyc(input bit p, input logic [7:0] d, input bit q, input bit r, input bit hc);
        push      = p;
        push_data = d;
        pop       = q;
        rst       = r;
        hwm_clr   = hc;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        push = 0; pop = 0; hwm_clr = 0; push_data = 0; rst = 1;
        af0 = 5'd12; ae0 = 5'd2; af1 = 3'd4; ae1 = 3'd1;

        // Reset state; almost_full follows a zero threshold straight after reset.
        cyc(0, 8'h00, 0, 1, 0);
        af0 = 5'd0; af1 = 3'd0; #1; check_all();
        af0 = 5'd12; af1 = 3'd4; #1; check_all();

        // Fill 17 into u0 (drop-newest), u1 overwrites oldest; then drain.
        for (int k = 0; k < 17; k++) cyc(1, 8'(k), 0, 0, 0);
        cyc(1, 8'h11, 0, 0, 0);
        for (int k = 0; k < 18; k++) cyc(0, 8'h00, 1, 0, 0);

        // Reset mid-operation with push and pop in the reset cycle.
        for (int k = 0; k < 7; k++) cyc(1, 8'(8'h40 + k), 0, 0, 0);
        cyc(1, 8'hEE, 1, 1, 0);

        // High-water mark reload: fill 9, drain to 4, clear.
        for (int k = 0; k < 9; k++) cyc(1, 8'(8'h60 + k), 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0);

        // Registered read: pop on empty, push A5, pop, then idle holds data.
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(1, 8'hA5, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0);

        // Pointer wrap with occupancy held at 3.
        for (int k = 0; k < 3; k++) cyc(1, 8'(8'h80 + k), 0, 0, 0);
        for (int k = 0; k < 23; k++) cyc(1, 8'(8'h90 + k), 1, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 8'h00, 1, 0, 0);

        // Randomized traffic with phase-dependent push/pop bias.
        for (int n = 0; n < 3000; n++) begin
            int pp, qp;
            if (n % 256 == 0) begin
                af0 = 5'($urandom_range(0, 16));
                ae0 = 5'($urandom_range(0, 16));
                af1 = 3'($urandom_range(0, 5));
                ae1 = 3'($urandom_range(0, 5));
            end
            case ((n / 300) % 3)
                0:       begin pp = 80; qp = 20; end
                1:       begin pp = 20; qp = 80; end
                default: begin pp = 50; qp = 50; end
            endcase
            cyc($urandom_range(0, 99) < pp, 8'($urandom),
                $urandom_range(0, 99) < qp,
                $urandom_range(0, 499) == 0,
                $urandom_range(0, 31) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_wm.md
# sync_fifo_wm

Parametrised successor to the event-path synchronous FIFO. It adds programmable almost-full and almost-empty watermarks, a selectable overflow policy (drop-newest or drop-oldest), and a selectable read mode (first-word-fall-through or registered). It also keeps a saturating drop counter and a clearable high-water mark. It sits between event capture and the downstream formatter, where bursts can exceed drain rate and loss must be counted, not silent.

## Interface
- W, 72: data width in bits.
- DEPTH, 16: entries; any integer >= 2 (non-power-of-2 legal).
- FWFT, 1: 1 = head visible combinationally; 0 = registered read, 1-cycle latency.
- OVF_MODE, 0: 0 = drop incoming word when full; 1 = overwrite oldest word when full.
- DROPW, 16: drop counter width.
- CW (localparam) = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset. Synchronous and active-high: one clock; reset is synchronous and active-high.
- push  in  1  write request.
- push_data  in  W  write data.
- pop  in  1  read request.
- pop_data  out  W  read data (see Operation).
- pop_valid  out  1  pop_data qualifier.
- empty, full  out  1  count==0 / count==DEPTH.
- count  out  CW  current occupancy (registered).
- afull_thresh, aempty_thresh  in  CW  watermark levels, quasi-static.
- almost_full  out  1  count >= afull_thresh.
- almost_empty  out  1  count <= aempty_thresh.
- overflow, underflow  out  1  single-cycle event pulses (registered).
- drop_count  out  DROPW  words lost to overflow, saturating at all-ones.
- hwm  out  CW  highest count reached since reset/clear.
- hwm_clr  in  1  reload hwm with next count.

## Operation
- Effective pop: do_pop = pop & !empty.
- Normal push: do_push = push & (!full | do_pop). Writes mem[wptr]; wptr wraps DEPTH-1 -> 0 explicitly (not by bit overflow).
- Push when full without pop:
  - OVF_MODE=0: data discarded; pointers and count unchanged.
  - OVF_MODE=1: write mem[wptr], advance both wptr and rptr; count stays DEPTH. The oldest word is lost.
  - Both modes: overflow=1 next cycle, drop_count += 1 (saturating).
- Push and pop when full: both proceed, count unchanged, no overflow, in both modes.
- Pop when empty: underflow=1 next cycle; no pointer or count change. A simultaneous push is still accepted; there is no bypass, so the word appears next cycle.
- count: +1 on push-only, -1 on pop-only, unchanged otherwise (including drop-oldest overwrite).
- empty, full, almost_full and almost_empty are combinational from the count register and the thresholds.
- hwm: hwm_clr=1 loads count_next; otherwise hwm <= max(hwm, count_next).
- FWFT=1:
  - pop_data = mem[rptr] when !empty, else 0.
  - pop_valid = !empty.
  - pop consumes the displayed word.
- FWFT=0:
  - On do_pop, pop_data <= mem[rptr] and pop_valid <= 1 for one cycle.
  - Otherwise pop_valid <= 0 and pop_data holds its last value.

## Timing
- After reset (rst high at an edge): pointers, count, drop_count, hwm, overflow, underflow, pop_valid(FWFT=0) and pop_data(FWFT=0) are 0.
- Derived values after reset: empty=1, full=0, almost_empty=1. almost_full = (afull_thresh==0).
- rst asserted mid-operation: contents are abandoned, outputs take reset values at the next edge, and push/pop in that cycle are ignored.
- Write-to-read latency: a word pushed at edge N is visible at the head after edge N (FWFT=1 pop_data valid in cycle N+1). With FWFT=0, a pop in cycle N+1 gives data after edge N+2.
- overflow and underflow assert for exactly one cycle per offending request cycle; back-to-back offences give a continuous high.
- Memory needs no reset; reads of unwritten entries are never exposed.

## Test plan
- DEPTH=16, W=8, FWFT=1, OVF_MODE=0: push 0x00..0x10 (17 words) -> full after the 16th push; 17th gives overflow pulse, drop_count=1, hwm=16; then pop 16 -> data 0x00..0x0F in order, then empty=1.
- Same fill with OVF_MODE=1: pushes 0x00..0x11 (18) -> drop_count=2, count=16; pops return 0x02..0x11.
- Wrap: DEPTH=5, 23 alternating push/pop pairs with count held at 3 -> FIFO order intact across pointer wrap, count constant, no overflow/underflow.
- Watermarks: afull_thresh=12, aempty_thresh=2. Fill 0->16 then drain -> almost_empty high for count<=2; almost_full high for count>=12, toggling exactly at 12/11 and 2/3.
- FWFT=0: pop on empty -> underflow=1, pop_valid=0. Push 0xA5, then pop next cycle -> pop_valid=1 and pop_data=0xA5 one cycle after the pop, then pop_valid=0 with pop_data held at 0xA5.
- Reset and clear: assert rst with count=7 and drop_count=3 -> all reset values next edge. Fill to 9, pulse hwm_clr with count=4 -> hwm=4.
